// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - digit-slot scan sequencer with frame-synchronous shadow digits and blanking
module display_scan_scheduler #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] score_bcd,
    input  logic        load,
    input  logic        lzb_en,
    output logic        ready,
    output logic        load_done,
    output logic [2:0]  refresh_counter,
    output logic [31:0] digits_q,
    output logic        blank,
    output logic        frame_tick
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]    refresh_q, refresh_d;
    logic          ready_q, ready_d;
    logic          load_done_q, load_done_d;
    logic          frame_tick_q, frame_tick_d;
    logic [31:0]   pend_q, pend_d;
    logic [31:0]   shadow_q, shadow_d;

    logic slot_end;
    logic frame_end;
    logic accept;
    logic commit;

    // ready_q low means the pending register holds an uncommitted value
    assign slot_end  = (slot_cnt_q == LAST);
    assign frame_end = slot_end && (refresh_q == 3'd7);
    assign accept    = load && ready_q;
    assign commit    = frame_end && !ready_q;

    always_comb begin
        slot_cnt_d   = slot_end ? '0 : slot_cnt_q + 1'b1;
        refresh_d    = slot_end ? refresh_q + 3'd1 : refresh_q;
        frame_tick_d = frame_end;
        load_done_d  = commit;
        pend_d       = accept ? score_bcd : pend_q;
        shadow_d     = commit ? pend_q : shadow_q;
        ready_d      = ready_q;
        if (accept) begin
            ready_d = 1'b0;
        end else if (commit) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            refresh_q    <= 3'd0;
            ready_q      <= 1'b1;
            load_done_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            pend_q       <= 32'd0;
            shadow_q     <= 32'd0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            refresh_q    <= refresh_d;
            ready_q      <= ready_d;
            load_done_q  <= load_done_d;
            frame_tick_q <= frame_tick_d;
            pend_q       <= pend_d;
            shadow_q     <= shadow_d;
        end
    end

    logic       win;
    logic [7:0] dz;
    logic [7:0] zero_from;
    logic       suppress;

    if (BLANK > 0) begin : g_win
        assign win = (slot_cnt_q < CW'(BLANK));
    end else begin : g_nowin
        assign win = 1'b0;
    end

    // zero_from[i]: digits 7 down to i are all zero; codes above 9 count as nonzero
    for (genvar g = 0; g < 8; g++) begin : g_lz
        assign dz[g]        = (shadow_q[4*g +: 4] == 4'd0);
        assign zero_from[g] = &dz[7:g];
    end

    assign suppress = lzb_en && (refresh_q != 3'd0) && zero_from[refresh_q];

    assign blank           = win || suppress;
    assign ready           = ready_q;
    assign load_done       = load_done_q;
    assign refresh_counter = refresh_q;
    assign digits_q        = shadow_q;
    assign frame_tick      = frame_tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb/tb_display_scan_scheduler.sv - directed self-checking bench for display_scan_scheduler
module tb_display_scan_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] score_bcd;
    logic        load;
    logic        lzb_en;
    logic        ready;
    logic        load_done;
    logic [2:0]  refresh_counter;
    logic [31:0] digits_q;
    logic        blank;
    logic        frame_tick;

    int n_checks;
    int n_fail;
    int cyc;

    display_scan_scheduler #(.DIV(4), .BLANK(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .score_bcd       (score_bcd),
        .load            (load),
        .lzb_en          (lzb_en),
        .ready           (ready),
        .load_done       (load_done),
        .refresh_counter (refresh_counter),
        .digits_q        (digits_q),
        .blank           (blank),
        .frame_tick      (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance to the next negedge; cyc = active edges since reset release
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (refresh_counter !== 3'd0) begin n_fail++; $display("FAIL reset_refresh got %0d exp 0", refresh_counter); end
        n_checks++;
        if (digits_q !== 32'd0) begin n_fail++; $display("FAIL reset_digits got %h exp 0", digits_q); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_checks++;
        if (load_done !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses load_done=%b frame_tick=%b exp 0 0", load_done, frame_tick);
        end
        n_checks++;
        if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank got %b exp 1", blank); end
        do_reset();
    endtask

    task automatic test_free_run();
        lzb_en = 1'b0;
        do_reset();
        for (int n = 1; n <= 70; n++) begin
            step();
            n_checks++;
            if (refresh_counter !== 3'((n / 4) % 8)) begin
                n_fail++; $display("FAIL free_refresh cyc %0d got %0d exp %0d", n, refresh_counter, (n / 4) % 8);
            end
            n_checks++;
            if (blank !== (n % 4 == 0)) begin
                n_fail++; $display("FAIL free_blank cyc %0d got %b exp %b", n, blank, (n % 4 == 0));
            end
            n_checks++;
            if (frame_tick !== (n % 32 == 0)) begin
                n_fail++; $display("FAIL free_frame_tick cyc %0d got %b exp %b", n, frame_tick, (n % 32 == 0));
            end
        end
    endtask

    task automatic test_load_mid_frame();
        int early;
        lzb_en = 1'b0;
        do_reset();
        step_to(13);
        score_bcd = 32'h0001_2345;
        load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_drop got %b exp 0", ready); end
        early = 0;
        while (cyc < 31) begin
            step();
            if (digits_q !== 32'd0 || load_done !== 1'b0 || ready !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL mid_hold_before_wrap got %0d bad cycles exp 0", early); end
        step();
        n_checks++;
        if (digits_q !== 32'h0001_2345) begin n_fail++; $display("FAIL mid_commit_digits got %h exp 00012345", digits_q); end
        n_checks++;
        if (load_done !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_commit_flags load_done=%b ready=%b exp 1 1", load_done, ready);
        end
        step();
        n_checks++;
        if (load_done !== 1'b0) begin n_fail++; $display("FAIL mid_done_width got %b exp 0", load_done); end
    endtask

    task automatic test_load_busy();
        int dones;
        step_to(34);
        score_bcd = 32'h0000_0777;
        load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", ready); end
        step_to(40);
        score_bcd = 32'h9999_9999;
        load = 1'b1;
        step();
        load = 1'b0;
        dones = 0;
        while (cyc < 70) begin
            step();
            if (load_done === 1'b1) dones++;
            if (cyc == 64) begin
                n_checks++;
                if (digits_q !== 32'h0000_0777 || load_done !== 1'b1) begin
                    n_fail++; $display("FAIL busy_commit digits=%h load_done=%b exp 00000777 1", digits_q, load_done);
                end
            end
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL busy_single_done got %0d exp 1", dones); end
        n_checks++;
        if (digits_q !== 32'h0000_0777) begin n_fail++; $display("FAIL busy_final_digits got %h exp 00000777", digits_q); end
    endtask

    task automatic test_lzb();
        int bad_a, bad_b, bad_c, bad_d;
        logic exp_b;
        lzb_en = 1'b1;
        do_reset();
        bad_d = 0;
        for (int n = 1; n <= 32; n++) begin
            step();
            exp_b = (n % 4 == 0) || (((n / 4) % 8) != 0);
            if (blank !== exp_b) bad_d++;
        end
        n_checks++;
        if (bad_d != 0) begin n_fail++; $display("FAIL lzb_all_zero got %0d bad cycles exp 0", bad_d); end
        step_to(66);
        score_bcd = 32'h0001_2345;
        load = 1'b1;
        step();
        load = 1'b0;
        step_to(95);
        bad_a = 0;
        for (int n = 96; n <= 127; n++) begin
            step();
            exp_b = (n % 4 == 0) || (((n / 4) % 8) >= 5);
            if (blank !== exp_b) bad_a++;
        end
        n_checks++;
        if (bad_a != 0) begin n_fail++; $display("FAIL lzb_12345 got %0d bad cycles exp 0", bad_a); end
        lzb_en = 1'b0;
        bad_b = 0;
        for (int n = 128; n <= 159; n++) begin
            step();
            if (n == 130) begin
                score_bcd = 32'h00F0_0000;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (blank !== (n % 4 == 0)) bad_b++;
        end
        n_checks++;
        if (bad_b != 0) begin n_fail++; $display("FAIL lzb_disabled got %0d bad cycles exp 0", bad_b); end
        lzb_en = 1'b1;
        bad_c = 0;
        for (int n = 160; n <= 191; n++) begin
            step();
            exp_b = (n % 4 == 0) || (((n / 4) % 8) >= 6);
            if (blank !== exp_b) bad_c++;
        end
        n_checks++;
        if (digits_q !== 32'h00F0_0000) begin n_fail++; $display("FAIL lzb_hex_load got %h exp 00f00000", digits_q); end
        n_checks++;
        if (bad_c != 0) begin n_fail++; $display("FAIL lzb_hex_digit got %0d bad cycles exp 0", bad_c); end
        lzb_en = 1'b0;
    endtask

    task automatic test_boundary_accept();
        int early;
        do_reset();
        step_to(31);
        score_bcd = 32'h0000_0042;
        load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (frame_tick !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL bnd_accept frame_tick=%b ready=%b exp 1 0", frame_tick, ready);
        end
        n_checks++;
        if (load_done !== 1'b0 || digits_q !== 32'd0) begin
            n_fail++; $display("FAIL bnd_no_early_commit load_done=%b digits=%h exp 0 0", load_done, digits_q);
        end
        early = 0;
        while (cyc < 63) begin
            step();
            if (load_done === 1'b1 || digits_q !== 32'd0) early++;
        end
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL bnd_hold got %0d bad cycles exp 0", early); end
        step();
        n_checks++;
        if (digits_q !== 32'h0000_0042 || load_done !== 1'b1) begin
            n_fail++; $display("FAIL bnd_commit digits=%h load_done=%b exp 00000042 1", digits_q, load_done);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        step_to(2);
        score_bcd = 32'h0000_0055;
        load = 1'b1;
        step();
        load = 1'b0;
        step_to(40);
        score_bcd = 32'h0000_0066;
        load = 1'b1;
        step();
        load = 1'b0;
        step_to(46);
        n_checks++;
        if (digits_q !== 32'h0000_0055 || ready !== 1'b0 || refresh_counter !== 3'd3) begin
            n_fail++; $display("FAIL arst_pre digits=%h ready=%b refresh=%0d exp 00000055 0 3", digits_q, ready, refresh_counter);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (digits_q !== 32'd0 || refresh_counter !== 3'd0) begin
            n_fail++; $display("FAIL arst_immediate digits=%h refresh=%0d exp 0 0", digits_q, refresh_counter);
        end
        n_checks++;
        if (ready !== 1'b1 || load_done !== 1'b0 || frame_tick !== 1'b0 || blank !== 1'b1) begin
            n_fail++; $display("FAIL arst_flags ready=%b done=%b tick=%b blank=%b exp 1 0 0 1", ready, load_done, frame_tick, blank);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        bad = 0;
        while (cyc < 40) begin
            step();
            if (load_done === 1'b1 || digits_q !== 32'd0) bad++;
            if (cyc == 3 && refresh_counter !== 3'd0) bad++;
            if (cyc == 4 && refresh_counter !== 3'd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL arst_restart got %0d bad cycles exp 0", bad); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b0;
        load      = 1'b0;
        lzb_en    = 1'b0;
        score_bcd = 32'd0;
        test_reset();
        test_free_run();
        test_load_mid_frame();
        test_load_busy();
        test_lzb();
        test_boundary_accept();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Sequencing controller for the 8-digit seven-segment scan path. It generates the 3-bit digit-select count that drives the digit/anode mux, with a programmable slot period and an anti-ghosting blank window at the start of each slot. It holds a shadow copy of the eight BCD score digits that is updated only at frame boundaries through a load/ready handshake, so a scan frame never shows a mix of old and new digits. It also applies optional leading-zero blanking. It sits between the score counter and the digit mux; the mux's anode output is forced off (all ones) whenever `blank` is high.

## Interface
- `DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, default 1000: cycles at the start of each slot with all digits off; 0 ≤ `BLANK` < `DIV`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `score_bcd`  in  32  eight BCD digits; [3:0] = digit 0 (LSB), [31:28] = digit 7.
- `load`  in  1  request to capture `score_bcd`; accepted only when `ready` = 1.
- `lzb_en`  in  1  leading-zero blanking enable; sampled live.
- `ready`  out  1  1 = no update pending; `load` will be accepted.
- `load_done`  out  1  one-cycle pulse when a pending value is committed to the shadow.
- `refresh_counter`  out  3  current digit slot, 0..7.
- `digits_q`  out  32  shadow digits; same layout as `score_bcd`.
- `blank`  out  1  1 = current slot must be dark.
- `frame_tick`  out  1  one-cycle pulse on the slot-7→0 wrap.

## Operation
**Slot counter**
- `slot_cnt` counts 0..`DIV`-1 every cycle.
- At `DIV`-1 it returns to 0 and `refresh_counter` increments modulo 8.
- The cycle in which `refresh_counter` goes 7→0 is the frame boundary. `frame_tick` is 1 in the first cycle of slot 0.

**Handshake**
- `load` && `ready` at a clock edge:
  - `score_bcd` is captured into a pending register.
  - `ready` goes to 0 on that edge.
- `load` while `ready` = 0 is ignored; the pending value is not overwritten.
- At a frame boundary edge with pending valid:
  - `digits_q` ← pending.
  - `ready` → 1.
  - `load_done` = 1 for that one cycle.
- Simultaneous events:
  - A load accepted on the same edge as a frame boundary, with nothing pending beforehand, is not committed at that boundary. It waits for the next one.
  - A commit and a new accept cannot coincide, because `ready` is 0 until the commit edge.

**Blanking**
- `blank` = (`slot_cnt` < `BLANK`) OR suppressed(`refresh_counter`).
- With `lzb_en` = 1, digit *i* (1..7) is suppressed if `digits_q` digits 7 down to *i* are all 0.
- Digit 0 is never suppressed.
- BCD values above 9 are treated as nonzero and passed through unchanged.
- With `lzb_en` = 0, no digit is suppressed.

**Output paths**
- `refresh_counter`, `digits_q`, `ready`, `load_done` and `frame_tick` are registered.
- `blank` is combinational from registered state and `lzb_en` only. There is no path from `score_bcd` or `load` to any output.

## Timing
- Reset values (held while `rst` = 1, asynchronous):
  - `slot_cnt` = 0, `refresh_counter` = 0.
  - `digits_q` = 0, pending invalid.
  - `ready` = 1, `load_done` = 0, `frame_tick` = 0.
  - `blank` = 1 if `BLANK` > 0, else 0.
- After release, `refresh_counter` advances first at cycle `DIV` (counting the first active edge as cycle 1). The first `frame_tick` occurs at cycle 8·`DIV`.
- Frame period = 8·`DIV` cycles. Slot *k* occupies `DIV` cycles, of which the first `BLANK` are dark.
- Load-to-display latency: from 1 to 8·`DIV` cycles after acceptance, always ending exactly at a frame boundary.
- `ready` is low from the accept edge through the commit edge; it reads 1 again in the `load_done` cycle.
- Reset mid-operation:
  - A pending load is discarded with no `load_done`.
  - The shadow clears to 0.
  - Scanning restarts at slot 0, `slot_cnt` 0.

## Test plan
- **Free run**, `DIV`=4, `BLANK`=1, no loads: `refresh_counter` steps 0..7 every 4 cycles; `blank` = 1 exactly in the first cycle of each slot; `frame_tick` appears every 32 cycles.
- **Load mid-frame**: `score_bcd`=0x00012345 loaded in slot 3 → `ready` drops next edge; `digits_q` stays 0 until the 7→0 wrap; at the wrap `digits_q`=0x00012345, `load_done`=1 for 1 cycle, `ready`=1.
- **Load while busy**: second `load` with 0x99999999 while `ready`=0 → ignored; commit shows the first value only; a single `load_done`.
- **Leading-zero blanking**: `digits_q`=0x00012345, `lzb_en`=1 → `blank`=1 for all of slots 5–7 and in the blank window only for slots 0–4. `digits_q`=0 → slots 1–7 dark, slot 0 lit. `lzb_en`=0 → only blank windows dark.
- **Boundary accept**: `load` asserted on the wrap edge with nothing pending → committed one full frame (32 cycles) later, not immediately.
- **Async reset**: assert `rst` mid-slot with a load pending → all outputs at reset values immediately, without waiting for a clock edge; no `load_done`; after release, counting restarts from slot 0.
